// File: rtl/branch_resolve_pkg.sv
// Shared types and encodings for the execute-stage branch resolution unit.
// The compare-code encodings match the upstream rs1/rs2 comparator.
package branch_resolve_pkg;

   typedef enum logic [1:0] {
      BR_COND = 2'd0,
      BR_JAL  = 2'd1,
      BR_JALR = 2'd2,
      BR_RSVD = 2'd3
   } br_type_e;

   localparam logic [1:0] BRAN_GT  = 2'd0;
   localparam logic [1:0] BRAN_LT  = 2'd1;
   localparam logic [1:0] BRAN_EQ  = 2'd2;
   localparam logic [1:0] BRAN_ERR = 2'd3;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      IDLE  = 1'b0,
      REDIR = 1'b1
   } brres_state_e;

endpackage

// File: rtl/branch_resolve_if.sv
// Redirect/flush handshake between the branch resolution unit and fetch.
interface branch_resolve_if #(
   parameter int XLEN = 32
);
   logic            redirect_valid;
   logic            redirect_ready;
   logic [XLEN-1:0] redirect_pc;
   logic            flush;

   modport master (
      output redirect_valid,
      output redirect_pc,
      output flush,
      input  redirect_ready
   );

   modport slave (
      input  redirect_valid,
      input  redirect_pc,
      input  flush,
      output redirect_ready
   );
endinterface

// File: rtl/branch_resolve_cond_eval.sv
// Conditional-branch taken decision from funct3 and the signed/unsigned
// compare codes; an illegal funct3 or an error code on the used input forces not-taken.
module branch_cond_eval
   import branch_resolve_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic [1:0] eqz_i,
   input  logic [1:0] eqz_u_i,
   output logic       taken_o,
   output logic       err_o
);

   logic taken_s;
   logic err_s;

   // Select compare code and condition by funct3
   always_comb begin
      taken_s = 1'b0;
      err_s   = 1'b0;
      case (funct3_i)
         F3_BEQ: begin
            taken_s = (eqz_i == BRAN_EQ);
            err_s   = (eqz_i == BRAN_ERR);
         end
         F3_BNE: begin
            taken_s = (eqz_i != BRAN_EQ);
            err_s   = (eqz_i == BRAN_ERR);
         end
         F3_BLT: begin
            taken_s = (eqz_i == BRAN_LT);
            err_s   = (eqz_i == BRAN_ERR);
         end
         F3_BGE: begin
            taken_s = (eqz_i == BRAN_GT) || (eqz_i == BRAN_EQ);
            err_s   = (eqz_i == BRAN_ERR);
         end
         F3_BLTU: begin
            taken_s = (eqz_u_i == BRAN_LT);
            err_s   = (eqz_u_i == BRAN_ERR);
         end
         F3_BGEU: begin
            taken_s = (eqz_u_i == BRAN_GT) || (eqz_u_i == BRAN_EQ);
            err_s   = (eqz_u_i == BRAN_ERR);
         end
         default: begin
            taken_s = 1'b0;
            err_s   = 1'b1;
         end
      endcase
   end

   assign taken_o = taken_s & ~err_s;
   assign err_o   = err_s;

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: taken/target, mispredict detection,
// registered redirect/flush handshake to fetch and saturating perf counters.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid_i,
   input  logic [1:0]       br_type_i,
   input  logic [2:0]       funct3_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [XLEN-1:0]  rs1_i,
   input  logic [1:0]       rs1_rs2_eqz_i,
   input  logic [1:0]       rs1_rs2_eqz_u_i,
   input  logic             pred_taken_i,
   branch_resolve_if.master redir_if,
   output logic             stall_o,
   output logic [XLEN-1:0]  link_pc_o,
   output logic             misalign_exc_o,
   output logic             cmp_err_o,
   input  logic             cnt_clr_i,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam logic [0:0] ST_IDLE  = IDLE;
   localparam logic [0:0] ST_REDIR = REDIR;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [0:0]       state_q, state_d;
   logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
   logic             flush_q, flush_d;
   logic             misalign_q, misalign_d;
   logic             cmp_err_q, cmp_err_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic             cond_taken_s;
   logic             cond_err_s;
   logic             taken_s;
   logic             is_br_s;
   logic             is_jalr_s;
   logic             is_cond_s;
   logic [XLEN-1:0]  seq_pc_s;
   logic [XLEN-1:0]  jalr_sum_s;
   logic [XLEN-1:0]  target_s;
   logic [XLEN-1:0]  next_pc_s;
   logic             misalign_s;
   logic             mispred_s;
   logic             accept_s;
   logic             go_redir_s;

   branch_cond_eval u_cond_eval (
      .funct3_i (funct3_i),
      .eqz_i    (rs1_rs2_eqz_i),
      .eqz_u_i  (rs1_rs2_eqz_u_i),
      .taken_o  (cond_taken_s),
      .err_o    (cond_err_s)
   );

   assign seq_pc_s   = pc_i + XLEN'(4);
   assign jalr_sum_s = rs1_i + imm_i;
   assign link_pc_o  = seq_pc_s;

   // Resolve taken, target and mispredict for the instruction in EX
   always_comb begin
      taken_s   = 1'b0;
      is_br_s   = 1'b1;
      is_jalr_s = 1'b0;
      is_cond_s = 1'b0;
      target_s  = pc_i + imm_i;
      case (br_type_i)
         BR_COND: begin
            taken_s   = cond_taken_s;
            is_cond_s = 1'b1;
         end
         BR_JAL: begin
            taken_s = 1'b1;
         end
         BR_JALR: begin
            taken_s   = 1'b1;
            is_jalr_s = 1'b1;
            target_s  = {jalr_sum_s[XLEN-1:1], 1'b0};
         end
         default: begin
            is_br_s = 1'b0;
         end
      endcase
      next_pc_s  = taken_s ? target_s : seq_pc_s;
      misalign_s = taken_s & (target_s[1:0] != 2'b00);
      mispred_s  = is_jalr_s | (taken_s != pred_taken_i);
      accept_s   = br_valid_i & (state_q == ST_IDLE) & is_br_s;
      go_redir_s = accept_s & mispred_s & ~misalign_s;
   end

   // Next-state for the redirect FSM, pulses and counters
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (go_redir_s) begin
               state_d       = ST_REDIR;
               redirect_pc_d = next_pc_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REDIR: begin
            if (redir_if.redirect_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_REDIR;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      flush_d    = go_redir_s;
      misalign_d = accept_s & misalign_s;
      cmp_err_d  = accept_s & is_cond_s & cond_err_s;

      // Clear wins over a same-cycle increment
      if (cnt_clr_i) begin
         branch_cnt_d  = {CNT_W{1'b0}};
         mispred_cnt_d = {CNT_W{1'b0}};
      end else begin
         if (accept_s && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
         end else begin
            branch_cnt_d = branch_cnt_q;
         end
         if (go_redir_s && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
         end else begin
            mispred_cnt_d = mispred_cnt_q;
         end
      end
   end

   // State, redirect payload, pulses and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         redirect_pc_q <= {XLEN{1'b0}};
         flush_q       <= 1'b0;
         misalign_q    <= 1'b0;
         cmp_err_q     <= 1'b0;
         branch_cnt_q  <= {CNT_W{1'b0}};
         mispred_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         flush_q       <= flush_d;
         misalign_q    <= misalign_d;
         cmp_err_q     <= cmp_err_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign redir_if.redirect_valid = (state_q == ST_REDIR);
   assign redir_if.redirect_pc    = redirect_pc_q;
   assign redir_if.flush          = flush_q;
   assign stall_o                 = (state_q == ST_REDIR);
   assign misalign_exc_o          = misalign_q;
   assign cmp_err_o               = cmp_err_q;
   assign branch_cnt_o            = branch_cnt_q;
   assign mispred_cnt_o           = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed scoreboard bench for branch_resolve, built with 4-bit counters
// so saturation is reachable in a short run.
module tb_branch_resolve;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             br_valid;
   logic [1:0]       br_type;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  rs1;
   logic [1:0]       eqz;
   logic [1:0]       eqz_u;
   logic             pred_taken;
   logic             stall;
   logic [XLEN-1:0]  link_pc;
   logic             misalign_exc;
   logic             cmp_err;
   logic             cnt_clr;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   branch_resolve_if #(.XLEN(XLEN)) rif ();

   branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .br_valid_i      (br_valid),
      .br_type_i       (br_type),
      .funct3_i        (funct3),
      .pc_i            (pc),
      .imm_i           (imm),
      .rs1_i           (rs1),
      .rs1_rs2_eqz_i   (eqz),
      .rs1_rs2_eqz_u_i (eqz_u),
      .pred_taken_i    (pred_taken),
      .redir_if        (rif.master),
      .stall_o         (stall),
      .link_pc_o       (link_pc),
      .misalign_exc_o  (misalign_exc),
      .cmp_err_o       (cmp_err),
      .cnt_clr_i       (cnt_clr),
      .branch_cnt_o    (branch_cnt),
      .mispred_cnt_o   (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        fl;
      logic        st;
      logic        mis;
      logic        ce;
      logic [3:0]  bc;
      logic [3:0]  mc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [3:0] mbc = 4'd0;
   logic [3:0] mmc = 4'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] t, input logic [2:0] f3,
                        input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                        input logic [1:0] e, input logic [1:0] eu, input logic pt);
      @(negedge clk);
      br_valid = v; br_type = t; funct3 = f3; pc = p; imm = im; rs1 = r1;
      eqz = e; eqz_u = eu; pred_taken = pt;
   endtask

   task automatic idle();
      drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
   endtask

   // Push expected post-edge outputs, advance one clock, pop and compare
   task automatic tick(input logic rv, input logic [31:0] rpc, input logic fl, input logic st,
                       input logic mis, input logic ce, input logic incb, input logic incm);
      exp_t e;
      if (cnt_clr) begin
         mbc = 4'd0;
         mmc = 4'd0;
      end else begin
         if (incb && mbc != 4'hF) mbc = mbc + 4'd1;
         if (incm && mmc != 4'hF) mmc = mmc + 4'd1;
      end
      e.rv = rv; e.rpc = rpc; e.fl = fl; e.st = st; e.mis = mis; e.ce = ce; e.bc = mbc; e.mc = mmc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("redirect_valid", 32'(rif.redirect_valid), 32'(e.rv));
      if (e.rv) chk("redirect_pc", rif.redirect_pc, e.rpc);
      chk("flush", 32'(rif.flush), 32'(e.fl));
      chk("stall", 32'(stall), 32'(e.st));
      chk("misalign_exc", 32'(misalign_exc), 32'(e.mis));
      chk("cmp_err", 32'(cmp_err), 32'(e.ce));
      chk("branch_cnt", 32'(branch_cnt), 32'(e.bc));
      chk("mispred_cnt", 32'(mispred_cnt), 32'(e.mc));
   endtask

   initial begin
      rst_n = 1'b0; cnt_clr = 1'b0; rif.redirect_ready = 1'b1;
      br_valid = 1'b0; br_type = 2'd0; funct3 = 3'd0; pc = 32'h0; imm = 32'h0; rs1 = 32'h0;
      eqz = 2'd0; eqz_u = 2'd0; pred_taken = 1'b0;
      #2;
      chk("rst_redirect_valid", 32'(rif.redirect_valid), 32'd0);
      chk("rst_redirect_pc", rif.redirect_pc, 32'd0);
      chk("rst_flush", 32'(rif.flush), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_misalign", 32'(misalign_exc), 32'd0);
      chk("rst_cmp_err", 32'(cmp_err), 32'd0);
      chk("rst_branch_cnt", 32'(branch_cnt), 32'd0);
      chk("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // BEQ taken, predicted not-taken: one-cycle redirect
      drive(1'b1, 2'd0, 3'b000, 32'h100, 32'h20, 32'h0, 2'd2, 2'd0, 1'b0);
      #1 chk("link_pc_beq", link_pc, 32'h104);
      tick(1'b1, 32'h120, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      idle();
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // BLTU not-taken, predicted taken, fetch stalls three cycles
      drive(1'b1, 2'd0, 3'b110, 32'h200, 32'h40, 32'h0, 2'd1, 2'd0, 1'b1);
      rif.redirect_ready = 1'b0;
      tick(1'b1, 32'h204, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      idle();
      tick(1'b1, 32'h204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'd0, 3'b000, 32'h700, 32'h20, 32'h0, 2'd2, 2'd0, 1'b0);
      tick(1'b1, 32'h204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      tick(1'b1, 32'h204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      rif.redirect_ready = 1'b1;
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // JALR clears bit 0 of the target and always redirects
      drive(1'b1, 2'd2, 3'b000, 32'h300, 32'h4, 32'h1001, 2'd0, 2'd0, 1'b1);
      #1 chk("link_pc_jalr", link_pc, 32'h304);
      tick(1'b1, 32'h1004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      idle();
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // JAL to a misaligned target: exception pulse, no redirect
      drive(1'b1, 2'd1, 3'b000, 32'h400, 32'h6, 32'h0, 2'd0, 2'd0, 1'b0);
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle();
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Illegal funct3, then BGE with error code, back to back
      drive(1'b1, 2'd0, 3'b010, 32'h500, 32'h10, 32'h0, 2'd2, 2'd2, 1'b0);
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 2'd0, 3'b101, 32'h504, 32'h10, 32'h0, 2'd3, 2'd0, 1'b0);
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Correctly predicted BNE, then reserved type (not counted)
      drive(1'b1, 2'd0, 3'b001, 32'h500, 32'h10, 32'h0, 2'd0, 2'd0, 1'b1);
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 2'd3, 3'b000, 32'h600, 32'h8, 32'h0, 2'd2, 2'd0, 1'b1);
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Drive branch_cnt into saturation
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 2'd0, 3'b000, 32'h800 + 32'(i * 4), 32'h40, 32'h0, 2'd0, 2'd0, 1'b0);
         tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Clear with a concurrent branch yields zero, then counting resumes
      drive(1'b1, 2'd0, 3'b000, 32'h900, 32'h40, 32'h0, 2'd0, 2'd0, 1'b0);
      cnt_clr = 1'b1;
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 2'd0, 3'b000, 32'h904, 32'h40, 32'h0, 2'd0, 2'd0, 1'b0);
      cnt_clr = 1'b0;
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a pending redirect
      drive(1'b1, 2'd0, 3'b000, 32'hA00, 32'h20, 32'h0, 2'd2, 2'd0, 1'b0);
      rif.redirect_ready = 1'b0;
      tick(1'b1, 32'hA20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_redirect_valid", 32'(rif.redirect_valid), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_flush", 32'(rif.flush), 32'd0);
      chk("arst_branch_cnt", 32'(branch_cnt), 32'd0);
      chk("arst_mispred_cnt", 32'(mispred_cnt), 32'd0);
      mbc = 4'd0;
      mmc = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      rif.redirect_ready = 1'b1;
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'd0, 3'b000, 32'hB00, 32'h10, 32'h0, 2'd2, 2'd0, 1'b0);
      tick(1'b1, 32'hB10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      idle();
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
